// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds architectural register indices, FSM states and init values.
package reg_file_pkg;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_FP   = 30;
    localparam int unsigned REG_RA   = 31;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_t;

    // Reset value of one entry; the named entries only exist
    // when the file has all 32 architectural registers.
    function automatic logic [63:0] init_value(
        input int unsigned addr,
        input int unsigned depth,
        input logic [63:0] ra,
        input logic [63:0] fp,
        input logic [63:0] sp
    );
        logic [63:0] v;
        v = '0;
        if (depth >= 32) begin
            if (addr == REG_RA) v = ra;
            else if (addr == REG_FP) v = fp;
            else if (addr == REG_SP) v = sp;
        end
        return v;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: zero check, write bypass, output flop.
// Ports: clk/rst_n, rd_en_i/rd_addr_i, arr_data_i, write bus, state_i, rd_data_o.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_WR = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rd_en_i,
    input  logic [ADDR_W-1:0]        rd_addr_i,
    input  logic [DATA_W-1:0]        arr_data_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  rf_state_t                state_i,
    output logic [DATA_W-1:0]        rd_data_o
);

    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Ascending scan so the highest-index matching writer wins.
    always_comb begin
        rd_data_d = arr_data_i;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en_i[j] &&
                wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i) begin
                rd_data_d = wr_data_i[j*DATA_W +: DATA_W];
            end
        end
        if (rd_addr_i == '0) rd_data_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (state_i == CLEAR) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with priority writes and post-reset clear.
// Ports: clk, rst_n, rd_en/rd_addr/rd_data, wr_en/wr_addr/wr_data, ready.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int              DATA_W  = 32,
    parameter int              ADDR_W  = 5,
    parameter int              NUM_RD  = 2,
    parameter int              NUM_WR  = 2,
    parameter logic [DATA_W-1:0] RA_INIT = 32'h80088008,
    parameter logic [DATA_W-1:0] FP_INIT = 32'h00012345,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h80020800
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     ready
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    rf_state_t         state_q;
    rf_state_t         state_d;
    logic [ADDR_W-1:0] clear_cnt_q;
    logic [ADDR_W-1:0] clear_cnt_d;
    logic              ready_q;
    logic              ready_d;
    logic [DATA_W-1:0] init_val;

    always_comb begin
        init_val = DATA_W'(init_value(32'(clear_cnt_q), DEPTH,
                                      64'(RA_INIT), 64'(FP_INIT),
                                      64'(SP_INIT)));
    end

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        ready_d     = ready_q;
        unique case (state_q)
            CLEAR: begin
                clear_cnt_d = clear_cnt_q + 1'b1;
                if (clear_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= CLEAR;
            clear_cnt_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
            ready_q     <= ready_d;
        end
    end

    // Array has no reset; the sweep defines every entry. Later
    // writes in the loop override earlier ones, so the
    // highest-index port wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == CLEAR) begin
                mem_q[clear_cnt_q] <= init_val;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (wr_en[j] &&
                        wr_addr[j*ADDR_W +: ADDR_W] != '0) begin
                        mem_q[wr_addr[j*ADDR_W +: ADDR_W]] <=
                            wr_data[j*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Bypass is only meaningful in RUN; ports force zero in CLEAR.
    logic [NUM_WR-1:0] wr_en_run;
    assign wr_en_run = (state_q == RUN) ? wr_en : '0;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [DATA_W-1:0] arr_rd;
        assign arr_rd = mem_q[rd_addr[i*ADDR_W +: ADDR_W]];

        reg_file_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rd (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_en_i    (rd_en[i]),
            .rd_addr_i  (rd_addr[i*ADDR_W +: ADDR_W]),
            .arr_data_i (arr_rd),
            .wr_en_i    (wr_en_run),
            .wr_addr_i  (wr_addr),
            .wr_data_i  (wr_data),
            .state_i    (state_q),
            .rd_data_o  (rd_data[i*DATA_W +: DATA_W])
        );
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp with hand-computed expectations.
// Covers sweep, writes, bypass, collisions, zero reg, hold, reset.
module tb_reg_file_mp;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        ready;

    int n_chk;
    int n_pass;
    int rise;

    reg_file_mp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd2(input logic [4:0] a0, input logic [4:0] a1);
        rd_en   = 2'b11;
        rd_addr = {a1, a0};
        step();
        rd_en   = 2'b00;
    endtask

    // Counts edges from release until ready; 0 means it never rose.
    task automatic sweep(input bit traffic, output int edges);
        edges = 0;
        for (int i = 1; i <= 40; i++) begin
            if (traffic) begin
                wr_en   = 2'b01;
                wr_addr = {5'd0, 5'd4};
                wr_data = {32'h0, 32'h00001234};
                rd_en   = 2'b11;
                rd_addr = {5'd30, 5'd31};
            end
            step();
            if (traffic && i == 16) begin
                chk("clear_rd0", rd_data[31:0], 32'h0);
                chk("clear_rd1", rd_data[63:32], 32'h0);
            end
            if (ready && edges == 0) begin
                edges = i;
                break;
            end
        end
        wr_en = 2'b00;
        rd_en = 2'b00;
    endtask

    initial begin
        n_chk   = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        rd_en   = '0;
        rd_addr = '0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        step();
        step();
        chk("rst_ready", {31'h0, ready}, 32'h0);
        chk("rst_rd0", rd_data[31:0], 32'h0);
        chk("rst_rd1", rd_data[63:32], 32'h0);

        rst_n = 1'b1;
        sweep(1'b1, rise);
        chk("sweep_len", rise, 32);
        chk("ready_rd0", rd_data[31:0], 32'h0);

        rd2(5'd31, 5'd30);
        chk("init_ra", rd_data[31:0], 32'h80088008);
        chk("init_fp", rd_data[63:32], 32'h00012345);
        rd2(5'd29, 5'd5);
        chk("init_sp", rd_data[31:0], 32'h80020800);
        chk("init_r5", rd_data[63:32], 32'h0);
        rd2(5'd31, 5'd4);
        chk("clear_drop_r4", rd_data[63:32], 32'h0);

        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd7};
        wr_data = {32'h0, 32'hDEADBEEF};
        step();
        wr_en = 2'b00;
        rd2(5'd7, 5'd7);
        chk("wr_r7_p0", rd_data[31:0], 32'hDEADBEEF);
        chk("wr_r7_p1", rd_data[63:32], 32'hDEADBEEF);

        wr_en   = 2'b11;
        wr_addr = {5'd9, 5'd9};
        wr_data = {32'h2, 32'h1};
        rd2(5'd9, 5'd9);
        wr_en = 2'b00;
        chk("byp_col_p0", rd_data[31:0], 32'h2);
        chk("byp_col_p1", rd_data[63:32], 32'h2);
        rd2(5'd9, 5'd7);
        chk("col_r9", rd_data[31:0], 32'h2);

        wr_en   = 2'b11;
        wr_addr = {5'd13, 5'd12};
        wr_data = {32'hD0D0D0D0, 32'hC0C0C0C0};
        rd2(5'd12, 5'd13);
        wr_en = 2'b00;
        chk("byp_r12", rd_data[31:0], 32'hC0C0C0C0);
        chk("byp_r13", rd_data[63:32], 32'hD0D0D0D0);
        rd2(5'd13, 5'd12);
        chk("mem_r13", rd_data[31:0], 32'hD0D0D0D0);
        chk("mem_r12", rd_data[63:32], 32'hC0C0C0C0);

        wr_en   = 2'b10;
        wr_addr = {5'd0, 5'd0};
        wr_data = {32'hFFFFFFFF, 32'h0};
        rd2(5'd0, 5'd0);
        wr_en = 2'b00;
        chk("zero_byp_p0", rd_data[31:0], 32'h0);
        chk("zero_byp_p1", rd_data[63:32], 32'h0);
        rd2(5'd0, 5'd0);
        chk("zero_mem", rd_data[31:0], 32'h0);

        rd2(5'd31, 5'd30);
        for (int k = 0; k < 3; k++) begin
            rd_addr = {5'(k + 5), 5'(k + 7)};
            step();
            chk("hold_p0", rd_data[31:0], 32'h80088008);
            chk("hold_p1", rd_data[63:32], 32'h00012345);
        end
        rd_en   = 2'b10;
        rd_addr = {5'd7, 5'd7};
        step();
        rd_en = 2'b00;
        chk("part_en_p0", rd_data[31:0], 32'h80088008);
        chk("part_en_p1", rd_data[63:32], 32'hDEADBEEF);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) step();
        chk("mid_busy", {31'h0, ready}, 32'h0);
        rst_n = 1'b0;
        step();
        chk("mid_rst_ready", {31'h0, ready}, 32'h0);
        chk("mid_rst_rd1", rd_data[63:32], 32'h0);
        rst_n = 1'b1;
        sweep(1'b0, rise);
        chk("mid_sweep_len", rise, 32);
        rd2(5'd31, 5'd30);
        chk("mid_ra", rd_data[31:0], 32'h80088008);
        chk("mid_fp", rd_data[63:32], 32'h00012345);
        rd2(5'd29, 5'd7);
        chk("mid_sp", rd_data[31:0], 32'h80020800);
        chk("mid_r7", rd_data[63:32], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
